id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register with a two-entry skid buffer between operand fetch/decode and the ALU.
- Carries instruction_s, both operand values, their register addresses and the PC; valid/ready on both sides.
- Synchronous flush is driven from the ALU's jump_now_o path.
- Optional writeback forwarding keeps held operands current while the stage is stalled.

Parameters:
- imem_addr_width_p, 10, PC width in instruction-memory words
- rf_addr_width_p, 5, register-file address width
- stall_cnt_width_p, 16, width of the saturating stall counter

Ports:
- clk  in  1  core clock, all state on rising edge
- n_reset  in  1  asynchronous active-low reset
- valid_i  in  1  upstream holds a valid decoded instruction
- ready_o  out  1  stage can accept; registered, a function of state only
- instr_i  in  16 (instruction_s)  decoded instruction
- rd_val_i  in  32  rd operand value
- rs_val_i  in  32  rs operand value
- rd_addr_i  in  rf_addr_width_p  rd register address
- rs_addr_i  in  rf_addr_width_p  rs register address
- pc_i  in  imem_addr_width_p  PC of the instruction
- flush_i  in  1  discard all held and incoming instructions
- wb_we_i  in  1  register-file write this cycle
- wb_addr_i  in  rf_addr_width_p  writeback address
- wb_data_i  in  32  writeback data
- valid_o  out  1  main entry valid toward the ALU
- ready_i  in  1  ALU side consumes this cycle
- instr_o  out  16  instruction to the ALU (op_i)
- rd_val_o  out  32  to ALU rd_i
- rs_val_o  out  32  to ALU rs_i
- rd_addr_o  out  rf_addr_width_p  rd address
- pc_o  out  imem_addr_width_p  PC
- stall_cnt_o  out  stall_cnt_width_p  cycles with valid_o=1 and ready_i=0, saturating

Behaviour:
- Handshakes: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Storage: main entry M drives all *_o payload outputs; skid entry S holds one extra instruction.
- State machine:
  - EMPTY: in_fire -> ONE (M <= input).
  - ONE: in_fire & out_fire -> ONE (M <= input); in_fire only -> FULL (S <= input); out_fire only -> EMPTY; neither -> hold.
  - FULL: out_fire -> ONE (M <= S); otherwise hold. No input is accepted in FULL.
- Outputs: ready_o = (state != FULL); valid_o = (state != EMPTY).
- Latency: 1 cycle from in_fire to valid_o. Full throughput of 1 instruction/cycle while ready_i=1.
- Payload outputs are stable while valid_o=1 and ready_i=0.
- flush_i (synchronous): next state EMPTY; highest priority. An in_fire in the same cycle is discarded (ready_o may still read 1). An out_fire in the same cycle is still counted as consumed by the ALU.
- Reset (any time, including mid-transfer):
  - state EMPTY, ready_o=1, valid_o=0;
  - all payload registers 0, so instr_o=0 decodes as NOP with zero operands;
  - stall_cnt_o=0.
- stall_cnt_o increments when valid_o & ~ready_i and saturates at all-ones. Flush does not clear it; only reset does.
- No arithmetic on payload; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_FWD_EN
- Defined:
  - Every cycle, for each valid entry (M, S), if wb_we_i and wb_addr_i != 0 and wb_addr_i equals the entry's rd_addr, that entry's rd_val <= wb_data_i. The same rule applies to rs_addr/rs_val.
  - The capture cycle is covered too: on in_fire, a matching incoming operand is stored as wb_data_i instead of the _i value.
  - Address 0 is never forwarded.
- Undefined:
  - Operands are stored exactly as presented and never updated.
  - Upstream must stall to resolve read-after-write hazards.
  - wb_* ports remain and are ignored.

Test Plan:
- Reset release, valid_i=1, instr=ADDU, rd=5, rs=7, ready_i=1 -> valid_o=1 one cycle later with rd_val_o=5, rs_val_o=7; ready_o stays 1; back-to-back stream of 8 instructions emerges in order, one per cycle.
- ready_i=0 while 2 instructions are sent -> ready_o falls after the second; third valid_i is not accepted; ready_i=1 -> instructions exit in order A, B; ready_o is 1 again after B is taken; stall_cnt_o equals the stalled cycle count.
- FULL state, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, instruction presented during flush never appears at the output.
- Assert n_reset while FULL mid-stall -> immediately valid_o=0, ready_o=1, instr_o=0, stall_cnt_o=0.
- ID_EX_FWD_EN defined: M holds rd_addr=3, rd_val=0x10 stalled; wb_we_i=1, wb_addr_i=3, wb_data_i=0xABCD -> rd_val_o=0xABCD next cycle. Repeat with wb_addr_i=0 -> value unchanged. Macro undefined -> value stays 0x10.
- Hold ready_i=0 for 70000 cycles with valid_o=1 -> stall_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage: decode -> ALU pipeline register with a two-entry skid buffer.
// Optional writeback forwarding into held operands: define ID_EX_FWD_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int imem_addr_width_p = 10,
  parameter int rf_addr_width_p   = 5,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                         clk,
  input  logic                         n_reset,
  // upstream side
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [15:0]                  instr_i,
  input  logic [31:0]                  rd_val_i,
  input  logic [31:0]                  rs_val_i,
  input  logic [rf_addr_width_p-1:0]   rd_addr_i,
  input  logic [rf_addr_width_p-1:0]   rs_addr_i,
  input  logic [imem_addr_width_p-1:0] pc_i,
  input  logic                         flush_i,
  // writeback snoop
  input  logic                         wb_we_i,
  input  logic [rf_addr_width_p-1:0]   wb_addr_i,
  input  logic [31:0]                  wb_data_i,
  // ALU side
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [15:0]                  instr_o,
  output logic [31:0]                  rd_val_o,
  output logic [31:0]                  rs_val_o,
  output logic [rf_addr_width_p-1:0]   rd_addr_o,
  output logic [imem_addr_width_p-1:0] pc_o,
  output logic [stall_cnt_width_p-1:0] stall_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [stall_cnt_width_p-1:0] CNT_ONE = {{(stall_cnt_width_p-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_fire;
  logic       out_fire;
  logic       load_m_in;
  logic       load_m_skid;
  logic       load_s;

  // main entry M
  logic [15:0]                  m_instr;
  logic [31:0]                  m_rd_val;
  logic [31:0]                  m_rs_val;
  logic [rf_addr_width_p-1:0]   m_rd_addr;
  logic [rf_addr_width_p-1:0]   m_rs_addr;
  logic [imem_addr_width_p-1:0] m_pc;

  // skid entry S
  logic [15:0]                  s_instr;
  logic [31:0]                  s_rd_val;
  logic [31:0]                  s_rs_val;
  logic [rf_addr_width_p-1:0]   s_rd_addr;
  logic [rf_addr_width_p-1:0]   s_rs_addr;
  logic [imem_addr_width_p-1:0] s_pc;

  // operand values after writeback forwarding (identity when disabled)
  logic [31:0] in_rd_val;
  logic [31:0] in_rs_val;
  logic [31:0] m_rd_cur;
  logic [31:0] m_rs_cur;
  logic [31:0] s_rd_cur;
  logic [31:0] s_rs_cur;

  logic [stall_cnt_width_p-1:0] stall_cnt;

  assign ready_o  = (state != ST_FULL);
  assign valid_o  = (state != ST_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

`ifdef ID_EX_FWD_EN
  logic wb_live;
  assign wb_live   = wb_we_i & (wb_addr_i != '0);
  assign in_rd_val = (wb_live && (wb_addr_i == rd_addr_i)) ? wb_data_i : rd_val_i;
  assign in_rs_val = (wb_live && (wb_addr_i == rs_addr_i)) ? wb_data_i : rs_val_i;
  assign m_rd_cur  = (wb_live && (wb_addr_i == m_rd_addr)) ? wb_data_i : m_rd_val;
  assign m_rs_cur  = (wb_live && (wb_addr_i == m_rs_addr)) ? wb_data_i : m_rs_val;
  assign s_rd_cur  = (wb_live && (wb_addr_i == s_rd_addr)) ? wb_data_i : s_rd_val;
  assign s_rs_cur  = (wb_live && (wb_addr_i == s_rs_addr)) ? wb_data_i : s_rs_val;
`else
  logic unused_fwd;
  assign in_rd_val  = rd_val_i;
  assign in_rs_val  = rs_val_i;
  assign m_rd_cur   = m_rd_val;
  assign m_rs_cur   = m_rs_val;
  assign s_rd_cur   = s_rd_val;
  assign s_rs_cur   = s_rs_val;
  assign unused_fwd = ^{wb_we_i, wb_addr_i, wb_data_i, m_rs_addr};
`endif

  // state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic; flush overrides every handshake
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_nxt = ST_FULL;
          else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // datapath load strobes
  always_comb begin
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (!flush_i) begin
      case (state)
        ST_EMPTY: load_m_in = in_fire;
        ST_ONE: begin
          load_m_in = in_fire & out_fire;
          load_s    = in_fire & ~out_fire;
        end
        ST_FULL:  load_m_skid = out_fire;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_instr   <= '0;
      m_rd_val  <= '0;
      m_rs_val  <= '0;
      m_rd_addr <= '0;
      m_rs_addr <= '0;
      m_pc      <= '0;
    end else if (load_m_in) begin
      m_instr   <= instr_i;
      m_rd_val  <= in_rd_val;
      m_rs_val  <= in_rs_val;
      m_rd_addr <= rd_addr_i;
      m_rs_addr <= rs_addr_i;
      m_pc      <= pc_i;
    end else if (load_m_skid) begin
      m_instr   <= s_instr;
      m_rd_val  <= s_rd_cur;
      m_rs_val  <= s_rs_cur;
      m_rd_addr <= s_rd_addr;
      m_rs_addr <= s_rs_addr;
      m_pc      <= s_pc;
    end else if (valid_o) begin
      m_rd_val  <= m_rd_cur;
      m_rs_val  <= m_rs_cur;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s_instr   <= '0;
      s_rd_val  <= '0;
      s_rs_val  <= '0;
      s_rd_addr <= '0;
      s_rs_addr <= '0;
      s_pc      <= '0;
    end else if (load_s) begin
      s_instr   <= instr_i;
      s_rd_val  <= in_rd_val;
      s_rs_val  <= in_rs_val;
      s_rd_addr <= rd_addr_i;
      s_rs_addr <= rs_addr_i;
      s_pc      <= pc_i;
    end else if (state == ST_FULL) begin
      s_rd_val  <= s_rd_cur;
      s_rs_val  <= s_rs_cur;
    end
  end

  // saturating stall counter; only reset clears it
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stall_cnt <= '0;
    end else if (valid_o && !ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign instr_o     = m_instr;
  assign rd_val_o    = m_rd_val;
  assign rs_val_o    = m_rs_val;
  assign rd_addr_o   = m_rd_addr;
  assign pc_o        = m_pc;
  assign stall_cnt_o = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] instr_i;
  logic [31:0] rd_val_i;
  logic [31:0] rs_val_i;
  logic [4:0]  rd_addr_i;
  logic [4:0]  rs_addr_i;
  logic [9:0]  pc_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] instr_o;
  logic [31:0] rd_val_o;
  logic [31:0] rs_val_o;
  logic [4:0]  rd_addr_o;
  logic [9:0]  pc_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .instr_i    (instr_i),
    .rd_val_i   (rd_val_i),
    .rs_val_i   (rs_val_i),
    .rd_addr_i  (rd_addr_i),
    .rs_addr_i  (rs_addr_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .wb_we_i    (wb_we_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .instr_o    (instr_o),
    .rd_val_o   (rd_val_o),
    .rs_val_o   (rs_val_o),
    .rd_addr_o  (rd_addr_o),
    .pc_o       (pc_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // one clock: inputs change and outputs are sampled on the falling edge
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    valid_i   = 1'b0;
    instr_i   = '0;
    rd_val_i  = '0;
    rs_val_i  = '0;
    rd_addr_i = '0;
    rs_addr_i = '0;
    pc_i      = '0;
    flush_i   = 1'b0;
    wb_we_i   = 1'b0;
    wb_addr_i = '0;
    wb_data_i = '0;
    ready_i   = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic send(input logic [15:0] ins, input logic [31:0] rdv, input logic [31:0] rsv,
                      input logic [4:0] rda, input logic [4:0] rsa, input logic [9:0] pcv);
    valid_i   = 1'b1;
    instr_i   = ins;
    rd_val_i  = rdv;
    rs_val_i  = rsv;
    rd_addr_i = rda;
    rs_addr_i = rsa;
    pc_i      = pcv;
  endtask

  task automatic test_reset;
    idle_inputs();
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({valid_o, ready_o} !== 2'b01) begin
      bad++; $display("FAIL reset_hs got %b want 01", {valid_o, ready_o});
    end
    total++;
    if ({instr_o, rd_val_o, rs_val_o, pc_o, stall_cnt_o} !== '0) begin
      bad++; $display("FAIL reset_payload got instr=%h rd=%h rs=%h pc=%h cnt=%h want all 0",
                      instr_o, rd_val_o, rs_val_o, pc_o, stall_cnt_o);
    end
    n_reset = 1'b1;
  endtask

  task automatic test_stream;
    do_reset();
    ready_i = 1'b1;
    send(16'h2A57, 32'd5, 32'd7, 5'd5, 5'd7, 10'd0);
    cyc();
    total++;
    if ({valid_o, ready_o, instr_o, rd_val_o, rs_val_o, rd_addr_o} !== {1'b1, 1'b1, 16'h2A57, 32'd5, 32'd7, 5'd5}) begin
      bad++; $display("FAIL first_out got v=%b r=%b instr=%h rd=%h rs=%h want v=1 r=1 instr=2a57 rd=5 rs=7",
                      valid_o, ready_o, instr_o, rd_val_o, rs_val_o);
    end
    for (int i = 0; i < 8; i++) begin
      send(16'h0100 + 16'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 5'(i + 1), 5'(i + 2), 10'(i + 1));
      cyc();
      total++;
      if ({valid_o, ready_o, instr_o, rd_val_o, rs_val_o, pc_o} !==
          {1'b1, 1'b1, 16'h0100 + 16'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 10'(i + 1)}) begin
        bad++; $display("FAIL stream[%0d] got v=%b r=%b instr=%h rd=%h pc=%h want instr=%h",
                        i, valid_o, ready_o, instr_o, rd_val_o, pc_o, 16'h0100 + 16'(i));
      end
    end
    valid_i = 1'b0;
    cyc();
    total++;
    if ({valid_o, stall_cnt_o} !== {1'b0, 16'd0}) begin
      bad++; $display("FAIL stream_drain got v=%b cnt=%0d want v=0 cnt=0", valid_o, stall_cnt_o);
    end
  endtask

  task automatic test_skid;
    do_reset();
    ready_i = 1'b0;
    send(16'hA001, 32'h11, 32'h12, 5'd1, 5'd2, 10'd1);
    cyc();
    total++;
    if ({valid_o, ready_o, instr_o, stall_cnt_o} !== {1'b1, 1'b1, 16'hA001, 16'd0}) begin
      bad++; $display("FAIL skid_a got v=%b r=%b instr=%h cnt=%0d want 1 1 a001 0", valid_o, ready_o, instr_o, stall_cnt_o);
    end
    send(16'hB002, 32'h21, 32'h22, 5'd3, 5'd4, 10'd2);
    cyc();
    total++;
    if ({valid_o, ready_o, instr_o, stall_cnt_o} !== {1'b1, 1'b0, 16'hA001, 16'd1}) begin
      bad++; $display("FAIL skid_full got v=%b r=%b instr=%h cnt=%0d want 1 0 a001 1", valid_o, ready_o, instr_o, stall_cnt_o);
    end
    send(16'hC003, 32'h31, 32'h32, 5'd5, 5'd6, 10'd3);
    cyc();
    total++;
    if ({ready_o, instr_o, stall_cnt_o} !== {1'b0, 16'hA001, 16'd2}) begin
      bad++; $display("FAIL skid_block got r=%b instr=%h cnt=%0d want 0 a001 2", ready_o, instr_o, stall_cnt_o);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    cyc();
    total++;
    if ({valid_o, ready_o, instr_o, rd_val_o, pc_o} !== {1'b1, 1'b1, 16'hB002, 32'h21, 10'd2}) begin
      bad++; $display("FAIL skid_b got v=%b r=%b instr=%h rd=%h pc=%h want 1 1 b002 21 2", valid_o, ready_o, instr_o, rd_val_o, pc_o);
    end
    cyc();
    total++;
    if ({valid_o, ready_o, stall_cnt_o} !== {1'b0, 1'b1, 16'd2}) begin
      bad++; $display("FAIL skid_end got v=%b r=%b cnt=%0d want 0 1 2", valid_o, ready_o, stall_cnt_o);
    end
  endtask

  task automatic test_flush;
    do_reset();
    ready_i = 1'b0;
    send(16'hA001, 32'h1, 32'h2, 5'd1, 5'd2, 10'd1);
    cyc();
    send(16'hB002, 32'h3, 32'h4, 5'd3, 5'd4, 10'd2);
    cyc();
    send(16'hC003, 32'h5, 32'h6, 5'd5, 5'd6, 10'd3);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    valid_i = 1'b0;
    total++;
    if ({valid_o, ready_o} !== 2'b01) begin
      bad++; $display("FAIL flush_full got v=%b r=%b want 0 1", valid_o, ready_o);
    end
    ready_i = 1'b1;
    cyc();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_no_c got v=%b instr=%h want v=0", valid_o, instr_o);
    end
    send(16'hD004, 32'h7, 32'h8, 5'd7, 5'd8, 10'd4);
    cyc();
    total++;
    if ({valid_o, instr_o} !== {1'b1, 16'hD004}) begin
      bad++; $display("FAIL flush_d got v=%b instr=%h want 1 d004", valid_o, instr_o);
    end
    send(16'hE005, 32'h9, 32'hA, 5'd9, 5'd10, 10'd5);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    valid_i = 1'b0;
    total++;
    if ({valid_o, ready_o} !== 2'b01) begin
      bad++; $display("FAIL flush_one got v=%b r=%b want 0 1", valid_o, ready_o);
    end
    cyc();
    total++;
    if (valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_no_e got v=%b instr=%h want v=0", valid_o, instr_o);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    ready_i = 1'b0;
    send(16'hA001, 32'h55, 32'h66, 5'd1, 5'd2, 10'd9);
    cyc();
    send(16'hB002, 32'h77, 32'h88, 5'd3, 5'd4, 10'd10);
    cyc();
    valid_i = 1'b0;
    cyc();
    total++;
    if ({ready_o, stall_cnt_o} !== {1'b0, 16'd2}) begin
      bad++; $display("FAIL pre_reset got r=%b cnt=%0d want 0 2", ready_o, stall_cnt_o);
    end
    #2;
    n_reset = 1'b0;
    #1;
    total++;
    if ({valid_o, ready_o, instr_o, rd_val_o, pc_o, stall_cnt_o} !== {1'b0, 1'b1, 16'h0, 32'h0, 10'h0, 16'h0}) begin
      bad++; $display("FAIL async_reset got v=%b r=%b instr=%h rd=%h pc=%h cnt=%0d want 0 1 0 0 0 0",
                      valid_o, ready_o, instr_o, rd_val_o, pc_o, stall_cnt_o);
    end
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_forward;
    logic [31:0] exp_rd;
    logic [31:0] exp_rs;
    do_reset();
    ready_i = 1'b0;
    send(16'h3333, 32'h10, 32'h20, 5'd3, 5'd4, 10'd5);
    cyc();
    valid_i = 1'b0;
    total++;
    if (rd_val_o !== 32'h10) begin
      bad++; $display("FAIL fwd_init got %h want 00000010", rd_val_o);
    end
    wb_we_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hABCD;
    cyc();
`ifdef ID_EX_FWD_EN
    exp_rd = 32'hABCD;
`else
    exp_rd = 32'h10;
`endif
    total++;
    if (rd_val_o !== exp_rd) begin
      bad++; $display("FAIL fwd_rd got %h want %h", rd_val_o, exp_rd);
    end
    wb_addr_i = 5'd0; wb_data_i = 32'h5555;
    cyc();
    total++;
    if (rd_val_o !== exp_rd) begin
      bad++; $display("FAIL fwd_addr0 got %h want %h", rd_val_o, exp_rd);
    end
    wb_addr_i = 5'd4; wb_data_i = 32'h77;
    cyc();
`ifdef ID_EX_FWD_EN
    exp_rs = 32'h77;
`else
    exp_rs = 32'h20;
`endif
    total++;
    if ({rs_val_o, rd_val_o} !== {exp_rs, exp_rd}) begin
      bad++; $display("FAIL fwd_rs got rs=%h rd=%h want rs=%h rd=%h", rs_val_o, rd_val_o, exp_rs, exp_rd);
    end
    wb_addr_i = 5'd9; wb_data_i = 32'h99;
    send(16'h4444, 32'h1, 32'h2, 5'd9, 5'd8, 10'd6);
    cyc();
    valid_i = 1'b0;
    wb_we_i = 1'b0;
    ready_i = 1'b1;
    cyc();
`ifdef ID_EX_FWD_EN
    exp_rd = 32'h99;
`else
    exp_rd = 32'h1;
`endif
    total++;
    if ({instr_o, rd_val_o, rs_val_o} !== {16'h4444, exp_rd, 32'h2}) begin
      bad++; $display("FAIL fwd_capture got instr=%h rd=%h rs=%h want 4444 %h 2", instr_o, rd_val_o, rs_val_o, exp_rd);
    end
    cyc();
  endtask

  task automatic test_saturate;
    do_reset();
    ready_i = 1'b0;
    send(16'h5555, 32'h1, 32'h2, 5'd1, 5'd2, 10'd7);
    cyc();
    valid_i = 1'b0;
    repeat (100) cyc();
    total++;
    if (stall_cnt_o !== 16'd100) begin
      bad++; $display("FAIL stall_100 got %0d want 100", stall_cnt_o);
    end
    repeat (69900) cyc();
    total++;
    if ({valid_o, stall_cnt_o} !== {1'b1, 16'hFFFF}) begin
      bad++; $display("FAIL stall_sat got v=%b cnt=%h want 1 ffff", valid_o, stall_cnt_o);
    end
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    total++;
    if ({valid_o, stall_cnt_o} !== {1'b0, 16'hFFFF}) begin
      bad++; $display("FAIL stall_after_flush got v=%b cnt=%h want 0 ffff", valid_o, stall_cnt_o);
    end
  endtask

  initial begin
    idle_inputs();
    n_reset = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_reset_mid();
    test_forward();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
